// File: rtl/ppg_beat_detector.sv
// IR-channel heartbeat peak detector with hysteresis, beat-interval measurement and per-beat AC/DC for RED and IR.
// Optional macro PPG_INTERVAL_AVG_EN: beat_interval reports a 4-beat moving average instead of the raw interval.
module ppg_beat_detector #(
    parameter int HYST         = 8,
    parameter int ARM_SAMPLES  = 16,
    parameter int MIN_INTERVAL = 20,
    parameter int MAX_INTERVAL = 400
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        enable,
    input  logic        sample_valid,
    input  logic [7:0]  IR_ADC_Value,
    input  logic [7:0]  RED_ADC_Value,
    output logic        beat_valid,
    output logic [11:0] beat_interval,
    output logic [7:0]  ir_ac,
    output logic [7:0]  ir_dc,
    output logic [7:0]  red_ac,
    output logic [7:0]  red_dc,
    output logic        beat_timeout,
    output logic        locked
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM     = 2'd1;
    localparam logic [1:0] ST_FALLING = 2'd2;
    localparam logic [1:0] ST_RISING  = 2'd3;

    localparam int               ARM_W    = $clog2(ARM_SAMPLES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_SAMPLES - 1);
    localparam logic [8:0]       HYST9    = 9'(HYST);
    localparam logic [11:0]      MIN_I    = 12'(MIN_INTERVAL);
    localparam logic [11:0]      MAX_I    = 12'(MAX_INTERVAL);

    logic [1:0]       state_q, state_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [11:0]      cnt_q, cnt_d;
    logic [7:0]       run_min_q, run_min_d, run_max_q, run_max_d;
    logic [7:0]       cyc_ir_max_q, cyc_ir_max_d, cyc_ir_min_q, cyc_ir_min_d;
    logic [7:0]       cyc_red_max_q, cyc_red_max_d, cyc_red_min_q, cyc_red_min_d;
    logic             locked_q, locked_d;
    logic             beat_valid_q, beat_valid_d;
    logic             beat_timeout_q, beat_timeout_d;
    logic [11:0]      beat_interval_q, beat_interval_d;
    logic [7:0]       ir_ac_q, ir_ac_d, ir_dc_q, ir_dc_d;
    logic [7:0]       red_ac_q, red_ac_d, red_dc_q, red_dc_d;

    logic [7:0]  run_min_upd, run_max_upd;
    logic [7:0]  ir_max_upd, ir_min_upd, red_max_upd, red_min_upd;
    logic [11:0] interval, report_interval;
    logic        timeout_hit, rise_hit, fall_hit, peak;

    // Running extremes including the sample currently on the inputs.
    always_comb begin
        run_min_upd = (IR_ADC_Value < run_min_q) ? IR_ADC_Value : run_min_q;
        run_max_upd = (IR_ADC_Value > run_max_q) ? IR_ADC_Value : run_max_q;
        ir_max_upd  = (IR_ADC_Value > cyc_ir_max_q) ? IR_ADC_Value : cyc_ir_max_q;
        ir_min_upd  = (IR_ADC_Value < cyc_ir_min_q) ? IR_ADC_Value : cyc_ir_min_q;
        red_max_upd = (RED_ADC_Value > cyc_red_max_q) ? RED_ADC_Value : cyc_red_max_q;
        red_min_upd = (RED_ADC_Value < cyc_red_min_q) ? RED_ADC_Value : cyc_red_min_q;
        interval    = cnt_q + 12'd1;
        timeout_hit = (interval >= MAX_I);
        rise_hit    = ({1'b0, IR_ADC_Value} >= ({1'b0, run_min_upd} + HYST9));
        fall_hit    = (({1'b0, IR_ADC_Value} + HYST9) <= {1'b0, run_max_upd});
    end

    always_comb begin
        state_d        = state_q;
        arm_cnt_d      = arm_cnt_q;
        cnt_d          = cnt_q;
        run_min_d      = run_min_q;
        run_max_d      = run_max_q;
        cyc_ir_max_d   = cyc_ir_max_q;
        cyc_ir_min_d   = cyc_ir_min_q;
        cyc_red_max_d  = cyc_red_max_q;
        cyc_red_min_d  = cyc_red_min_q;
        locked_d       = locked_q;
        beat_valid_d   = 1'b0;
        beat_timeout_d = 1'b0;
        ir_ac_d        = ir_ac_q;
        ir_dc_d        = ir_dc_q;
        red_ac_d       = red_ac_q;
        red_dc_d       = red_dc_q;
        peak           = 1'b0;

        if (!enable) begin
            state_d       = ST_IDLE;
            arm_cnt_d     = '0;
            cnt_d         = '0;
            locked_d      = 1'b0;
            run_min_d     = 8'hFF;
            run_max_d     = 8'h00;
            cyc_ir_max_d  = 8'h00;
            cyc_ir_min_d  = 8'hFF;
            cyc_red_max_d = 8'h00;
            cyc_red_min_d = 8'hFF;
        end else if (state_q == ST_IDLE) begin
            state_d   = ST_ARM;
            arm_cnt_d = '0;
        end else if (sample_valid) begin
            if (state_q == ST_ARM) begin
                if (arm_cnt_q == ARM_LAST) begin
                    state_d   = ST_FALLING;
                    run_min_d = IR_ADC_Value;
                    cnt_d     = '0;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                    run_min_d = run_min_upd;
                end
            end else begin
                cyc_ir_max_d  = ir_max_upd;
                cyc_ir_min_d  = ir_min_upd;
                cyc_red_max_d = red_max_upd;
                cyc_red_min_d = red_min_upd;
                if (state_q == ST_FALLING) begin
                    run_min_d = run_min_upd;
                    if (rise_hit) begin
                        state_d   = ST_RISING;
                        run_max_d = IR_ADC_Value;
                    end
                end else begin
                    run_max_d = run_max_upd;
                    if (fall_hit) begin
                        peak      = 1'b1;
                        state_d   = ST_FALLING;
                        run_min_d = IR_ADC_Value;
                    end
                end

                // Timeout outranks a coincident peak; a rejected peak keeps counting.
                if (timeout_hit) begin
                    beat_timeout_d = 1'b1;
                    locked_d       = 1'b0;
                    state_d        = ST_ARM;
                    arm_cnt_d      = '0;
                    cnt_d          = MAX_I;
                end else if (peak && !locked_q) begin
                    locked_d      = 1'b1;
                    cnt_d         = '0;
                    cyc_ir_max_d  = IR_ADC_Value;
                    cyc_ir_min_d  = IR_ADC_Value;
                    cyc_red_max_d = RED_ADC_Value;
                    cyc_red_min_d = RED_ADC_Value;
                end else if (peak && (interval >= MIN_I)) begin
                    beat_valid_d  = 1'b1;
                    cnt_d         = '0;
                    ir_ac_d       = ir_max_upd - ir_min_upd;
                    ir_dc_d       = 8'((9'(ir_max_upd) + 9'(ir_min_upd)) >> 1);
                    red_ac_d      = red_max_upd - red_min_upd;
                    red_dc_d      = 8'((9'(red_max_upd) + 9'(red_min_upd)) >> 1);
                    cyc_ir_max_d  = IR_ADC_Value;
                    cyc_ir_min_d  = IR_ADC_Value;
                    cyc_red_max_d = RED_ADC_Value;
                    cyc_red_min_d = RED_ADC_Value;
                end else begin
                    cnt_d = interval;
                end
            end
        end
    end

    assign beat_interval_d = beat_valid_d ? report_interval : beat_interval_q;

`ifdef PPG_INTERVAL_AVG_EN
    logic [3:0][11:0] hist_q, hist_d;
    logic             hist_full_q, hist_full_d;
    logic [13:0]      hist_sum;

    // The first accepted interval after lock fills the whole window so the average starts sane.
    always_comb begin
        hist_d      = hist_q;
        hist_full_d = hist_full_q;
        if (!enable || beat_timeout_d) begin
            hist_d      = '0;
            hist_full_d = 1'b0;
        end else if (beat_valid_d) begin
            hist_d      = hist_full_q ? {interval, hist_q[3:1]} : {4{interval}};
            hist_full_d = 1'b1;
        end
        hist_sum = 14'(hist_d[0]) + 14'(hist_d[1]) + 14'(hist_d[2]) + 14'(hist_d[3]);
    end

    assign report_interval = 12'(hist_sum >> 2);

    always_ff @(posedge CLK) begin
        if (rst) begin
            hist_q      <= '0;
            hist_full_q <= 1'b0;
        end else begin
            hist_q      <= hist_d;
            hist_full_q <= hist_full_d;
        end
    end
`else
    assign report_interval = interval;
`endif

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            arm_cnt_q       <= '0;
            cnt_q           <= '0;
            run_min_q       <= 8'hFF;
            run_max_q       <= 8'h00;
            cyc_ir_max_q    <= 8'h00;
            cyc_ir_min_q    <= 8'hFF;
            cyc_red_max_q   <= 8'h00;
            cyc_red_min_q   <= 8'hFF;
            locked_q        <= 1'b0;
            beat_valid_q    <= 1'b0;
            beat_timeout_q  <= 1'b0;
            beat_interval_q <= '0;
            ir_ac_q         <= '0;
            ir_dc_q         <= '0;
            red_ac_q        <= '0;
            red_dc_q        <= '0;
        end else begin
            state_q         <= state_d;
            arm_cnt_q       <= arm_cnt_d;
            cnt_q           <= cnt_d;
            run_min_q       <= run_min_d;
            run_max_q       <= run_max_d;
            cyc_ir_max_q    <= cyc_ir_max_d;
            cyc_ir_min_q    <= cyc_ir_min_d;
            cyc_red_max_q   <= cyc_red_max_d;
            cyc_red_min_q   <= cyc_red_min_d;
            locked_q        <= locked_d;
            beat_valid_q    <= beat_valid_d;
            beat_timeout_q  <= beat_timeout_d;
            beat_interval_q <= beat_interval_d;
            ir_ac_q         <= ir_ac_d;
            ir_dc_q         <= ir_dc_d;
            red_ac_q        <= red_ac_d;
            red_dc_q        <= red_dc_d;
        end
    end

    assign beat_valid    = beat_valid_q;
    assign beat_interval = beat_interval_q;
    assign ir_ac         = ir_ac_q;
    assign ir_dc         = ir_dc_q;
    assign red_ac        = red_ac_q;
    assign red_dc        = red_dc_q;
    assign beat_timeout  = beat_timeout_q;
    assign locked        = locked_q;

endmodule

// File: tb/tb_ppg_beat_detector.sv
// Randomized bench for ppg_beat_detector: a sample-level behavioural model predicts every output each cycle,
// plus directed pulse-train, refractory, timeout, hysteresis and enable-drop scenarios.
module tb_ppg_beat_detector;

    localparam int HYST         = 8;
    localparam int ARM_SAMPLES  = 16;
    localparam int MIN_INTERVAL = 20;
    localparam int MAX_INTERVAL = 400;

    logic        CLK = 1'b0;
    logic        rst, enable, sample_valid;
    logic [7:0]  ir_in, red_in;
    logic        beat_valid, beat_timeout, locked;
    logic [11:0] beat_interval;
    logic [7:0]  ir_ac, ir_dc, red_ac, red_dc;

    always #5 CLK = ~CLK;

    ppg_beat_detector #(
        .HYST(HYST), .ARM_SAMPLES(ARM_SAMPLES),
        .MIN_INTERVAL(MIN_INTERVAL), .MAX_INTERVAL(MAX_INTERVAL)
    ) dut (
        .CLK(CLK), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .IR_ADC_Value(ir_in), .RED_ADC_Value(red_in),
        .beat_valid(beat_valid), .beat_interval(beat_interval),
        .ir_ac(ir_ac), .ir_dc(ir_dc), .red_ac(red_ac), .red_dc(red_dc),
        .beat_timeout(beat_timeout), .locked(locked)
    );

    int check_count = 0;
    int error_count = 0;

    // Model: phase of the detector seen as "off / warming up / waiting for a rise / waiting for a fall".
    localparam int P_OFF = 0, P_WARMUP = 1, P_SEEK_RISE = 2, P_SEEK_FALL = 3;
    int m_phase = P_OFF, m_warm = 0, m_since = 0, m_lo = 255, m_hi = 0, m_locked = 0;
    int m_ir_hi = 0, m_ir_lo = 255, m_red_hi = 0, m_red_lo = 255;
    int m_hist[$];
    int e_valid = 0, e_timeout = 0, e_interval = 0;
    int e_ir_ac = 0, e_ir_dc = 0, e_red_ac = 0, e_red_dc = 0;

    logic cur_en = 1'b0;
    int   beats_seen = 0;
    int   obs_timeout = 0;
    int   captured[$];
    int   expected[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int report(input int iv);
`ifdef PPG_INTERVAL_AVG_EN
        int s;
        s = 0;
        if (m_hist.size() == 0) repeat (4) m_hist.push_back(iv);
        else begin
            m_hist.push_back(iv);
            void'(m_hist.pop_front());
        end
        foreach (m_hist[i]) s += m_hist[i];
        return s / 4;
`else
        return iv;
`endif
    endfunction

    task automatic restart_cycle(input int ir, input int red);
        m_ir_hi = ir; m_ir_lo = ir; m_red_hi = red; m_red_lo = red;
    endtask

    task automatic model_step(input int r, input int en, input int sv, input int ir, input int red);
        int iv;
        bit pk;
        e_valid = 0;
        e_timeout = 0;
        if (r != 0) begin
            m_phase = P_OFF; m_warm = 0; m_since = 0; m_locked = 0; m_lo = 255; m_hi = 0;
            m_ir_hi = 0; m_ir_lo = 255; m_red_hi = 0; m_red_lo = 255;
            m_hist.delete();
            e_interval = 0; e_ir_ac = 0; e_ir_dc = 0; e_red_ac = 0; e_red_dc = 0;
        end else if (en == 0) begin
            m_phase = P_OFF; m_locked = 0; m_since = 0;
            m_ir_hi = 0; m_ir_lo = 255; m_red_hi = 0; m_red_lo = 255;
            m_hist.delete();
        end else if (m_phase == P_OFF) begin
            m_phase = P_WARMUP;
            m_warm = 0;
        end else if (sv != 0) begin
            if (m_phase == P_WARMUP) begin
                m_warm++;
                if (m_warm == ARM_SAMPLES) begin
                    m_phase = P_SEEK_RISE; m_lo = ir; m_since = 0;
                end
            end else begin
                iv = m_since + 1;
                pk = 0;
                if (ir > m_ir_hi) m_ir_hi = ir;
                if (ir < m_ir_lo) m_ir_lo = ir;
                if (red > m_red_hi) m_red_hi = red;
                if (red < m_red_lo) m_red_lo = red;
                if (m_phase == P_SEEK_RISE) begin
                    if (ir < m_lo) m_lo = ir;
                    if (ir - m_lo >= HYST) begin m_phase = P_SEEK_FALL; m_hi = ir; end
                end else begin
                    if (ir > m_hi) m_hi = ir;
                    if (m_hi - ir >= HYST) begin pk = 1; m_phase = P_SEEK_RISE; m_lo = ir; end
                end
                if (iv >= MAX_INTERVAL) begin
                    e_timeout = 1; m_locked = 0; m_phase = P_WARMUP; m_warm = 0; m_hist.delete();
                end else if (pk && m_locked == 0) begin
                    m_locked = 1; m_since = 0; restart_cycle(ir, red);
                end else if (pk && iv >= MIN_INTERVAL) begin
                    e_valid    = 1;
                    e_interval = report(iv);
                    e_ir_ac    = m_ir_hi - m_ir_lo;
                    e_ir_dc    = (m_ir_hi + m_ir_lo) / 2;
                    e_red_ac   = m_red_hi - m_red_lo;
                    e_red_dc   = (m_red_hi + m_red_lo) / 2;
                    m_since    = 0;
                    restart_cycle(ir, red);
                end else begin
                    m_since = iv;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic sv,
                                 input logic [7:0] ir, input logic [7:0] red);
        rst = r; enable = en; sample_valid = sv; ir_in = ir; red_in = red;
        @(posedge CLK);
        model_step(int'(r), int'(en), int'(sv), int'(ir), int'(red));
        #1;
        checkOutput("beat_valid", beat_valid, e_valid);
        checkOutput("beat_timeout", beat_timeout, e_timeout);
        checkOutput("locked", locked, m_locked);
        checkOutput("beat_interval", beat_interval, e_interval);
        checkOutput("ir_ac", ir_ac, e_ir_ac);
        checkOutput("ir_dc", ir_dc, e_ir_dc);
        checkOutput("red_ac", red_ac, e_red_ac);
        checkOutput("red_dc", red_dc, e_red_dc);
        if (beat_valid === 1'b1) begin
            beats_seen++;
            captured.push_back(int'(beat_interval));
        end
        obs_timeout = (beat_timeout === 1'b1) ? 1 : 0;
    endtask

    task automatic send_sample(input int ir, input int red);
        repeat ($urandom_range(0, 2)) applyStimulus(1'b0, cur_en, 1'b0, 8'($urandom), 8'($urandom));
        applyStimulus(1'b0, cur_en, 1'b1, 8'(ir), 8'(red));
    endtask

    task automatic send_block(input int period);
        for (int i = 0; i < period; i++) begin
            if (i < period / 2) send_sample(100, 80);
            else                send_sample(160, 120);
        end
    endtask

    task automatic check_captured(input string tag);
        checkOutput({tag, "_count"}, captured.size(), expected.size());
        for (int i = 0; i < expected.size(); i++)
            checkOutput($sformatf("%s_%0d", tag, i), (i < captured.size()) ? captured[i] : -1, expected[i]);
    endtask

    initial begin
        int to_at;
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; ir_in = '0; red_in = '0;

        // Reset with random sample traffic and enable low.
        repeat (3) applyStimulus(1'b1, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        repeat (5) applyStimulus(1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_ir_ac", ir_ac, 0);
        checkOutput("reset_interval", beat_interval, 0);

        // Clean 50-sample pulse train, then a spurious spike 10 samples after a beat.
        cur_en = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        captured.delete();
        repeat (8) send_block(50);
        checkOutput("plan_train_locked", locked, 1);
        for (int i = 0; i < 10; i++) send_sample(100, 80);
        repeat (2) send_sample(160, 120);
        for (int i = 0; i < 13; i++) send_sample(100, 80);
        for (int i = 0; i < 25; i++) send_sample(160, 120);
        send_sample(100, 80);
        expected.delete();
        repeat (8) expected.push_back(50);
        check_captured("plan_train_interval");
        checkOutput("plan_ir_ac", ir_ac, 60);
        checkOutput("plan_ir_dc", ir_dc, 130);
        checkOutput("plan_red_ac", red_ac, 40);
        checkOutput("plan_red_dc", red_dc, 100);

        // Flat IR with 4-LSB ripple after lock: timeout on the 400th sample, then no beats.
        beats_seen = 0;
        to_at = 0;
        for (int k = 1; k <= 420; k++) begin
            send_sample(128 + $urandom_range(0, 3), 100 + $urandom_range(0, 3));
            if (obs_timeout != 0 && to_at == 0) to_at = k;
        end
        checkOutput("plan_timeout_at", to_at, MAX_INTERVAL);
        for (int k = 0; k < 100; k++) send_sample(128 + $urandom_range(0, 3), 100);
        checkOutput("plan_flat_beats", beats_seen, 0);
        checkOutput("plan_flat_locked", locked, 0);

        // Lock, drop enable mid-rise, then a fresh ARM and a scripted interval sequence.
        repeat (5) send_sample(100, 80);
        repeat (10) send_sample(160, 120);
        send_sample(100, 80);
        repeat (10) send_sample(160, 120);
        checkOutput("plan_pre_drop_locked", locked, 1);
        cur_en = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd160, 8'd120);
        checkOutput("plan_drop_locked", locked, 0);
        cur_en = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
        captured.delete();
        beats_seen = 0;
        repeat (20) send_sample(100, 80);
        repeat (10) send_sample(160, 120);
        checkOutput("plan_arm_beats", beats_seen, 0);
        checkOutput("plan_arm_locked", locked, 0);
        send_block(48); send_block(52); send_block(50); send_block(54);
        send_block(20); send_block(19); send_block(30);
        send_sample(100, 80);
        expected.delete();
`ifdef PPG_INTERVAL_AVG_EN
        expected = '{48, 49, 49, 51, 44, 43};
`else
        expected = '{48, 52, 50, 54, 20, 49};
`endif
        check_captured("plan_seq_interval");

        // Randomized pulse trains with occasional enable drops and resets.
        for (int n = 0; n < 40; n++) begin
            int p, lo, amp, sel;
            p   = $urandom_range(16, 80);
            lo  = $urandom_range(10, 120);
            amp = $urandom_range(4, 100);
            sel = $urandom_range(0, 99);
            if (sel < 5) begin
                cur_en = 1'b0;
                repeat ($urandom_range(1, 3)) applyStimulus(1'b0, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
                cur_en = 1'b1;
            end else if (sel < 8) begin
                applyStimulus(1'b1, cur_en, 1'($urandom), 8'($urandom), 8'($urandom));
            end
            for (int i = 0; i < p; i++) begin
                if (i < p / 2) send_sample(lo + $urandom_range(0, 3), lo / 2 + $urandom_range(0, 3));
                else           send_sample(lo + amp + $urandom_range(0, 3), lo / 2 + amp / 2 + $urandom_range(0, 3));
            end
        end
        for (int i = 0; i < 300; i++) send_sample($urandom_range(0, 255), $urandom_range(0, 255));

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/ppg_beat_detector.md
Name: ppg_beat_detector

Overview:
- Downstream stage of the pulse-oximeter LED/PGA controller.
- Consumes the per-LED ADC sample registers once the controller has found its DC-comp/PGA setting.
- Detects heartbeat peaks on the IR channel with hysteresis and measures beat-to-beat interval in samples.
- Per accepted beat, emits AC (peak-to-trough) and DC (midpoint) for both RED and IR, feeding the SpO2/heart-rate arithmetic stage.

Parameters:
- HYST, 8, hysteresis in ADC LSBs for peak/trough confirmation.
- ARM_SAMPLES, 16, samples observed after enable/timeout before detection starts.
- MIN_INTERVAL, 20, refractory; detections with interval below this are rejected.
- MAX_INTERVAL, 400, interval count at which beat_timeout fires (max 4095).

Ports:
- CLK, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- enable, input, 1, high while the controller is in operation (setting found).
- sample_valid, input, 1, one-cycle strobe; RED_ADC_Value/IR_ADC_Value hold a fresh pair.
- IR_ADC_Value, input, 8, IR sample.
- RED_ADC_Value, input, 8, RED sample.
- beat_valid, output, 1, one-cycle pulse per accepted beat.
- beat_interval, output, 12, samples between accepted beats.
- ir_ac, ir_dc, red_ac, red_dc, output, 8 each, per-beat AC/DC.
- beat_timeout, output, 1, one-cycle pulse on MAX_INTERVAL expiry.
- locked, output, 1, high after the first accepted peak following ARM.

Behaviour:
- Interface: one clock, CLK; reset rst is synchronous and active-high.
- Reset: all outputs 0, state IDLE, counters 0, trackers max=0/min=255.
- FSM states: IDLE, ARM, FALLING, RISING. State, trackers and counters change only on sample_valid, except IDLE entry.
- enable low (any state, including mid-beat): next cycle IDLE, locked=0, counters/trackers cleared. Registered outputs hold their last values.
- IDLE -> ARM on enable high. ARM counts ARM_SAMPLES samples, tracking IR run_min. On the last sample -> FALLING, with run_min = that sample.
- FALLING: run_min = min(run_min, IR). When IR >= run_min + HYST (9-bit compare): -> RISING, run_max = IR.
- RISING: run_max = max(run_max, IR). When IR + HYST <= run_max (9-bit, no underflow): peak detected -> FALLING, run_min = IR.
- Interval counter cnt, 12-bit:
  - Cleared to 0 at an accepted detection; +1 on every later sample_valid.
  - Detection interval = cnt+1, i.e. detections on samples 10 and 60 give 50.
- Detection while locked=0 (first after ARM): locked<=1, cnt cleared, cycle trackers reset, no beat_valid.
- Detection while locked=1:
  - interval < MIN_INTERVAL: rejected. FSM still moves to FALLING, cnt not cleared, trackers kept, no pulse.
  - Otherwise accepted: beat_valid pulses and all values below are registered the cycle after the detecting sample_valid (latency 1).
  - beat_interval = interval.
  - ir_ac = cyc_ir_max - cyc_ir_min; ir_dc = (cyc_ir_max + cyc_ir_min) >> 1, 9-bit sum. RED likewise.
  - Cycle trackers, which cover all samples since the previous accepted beat including the current one, are then reset to the current sample.
- Timeout: in FALLING/RISING, when cnt reaches MAX_INTERVAL on a sample_valid:
  - beat_timeout pulses (latency 1), locked<=0, -> ARM.
  - cnt saturates and never wraps.
- Timeout and detection on the same sample: timeout wins, no beat_valid.
- sample_valid asserted on consecutive cycles is legal; each strobe is one sample.

Optional Feature:
- PPG_INTERVAL_AVG_EN defined:
  - beat_interval = 4-beat moving average (14-bit sum >> 2) of accepted intervals.
  - The history is preloaded with the first accepted interval after lock.
  - Timeout or enable drop clears the history.
  - AC/DC are unaffected.
- Undefined: beat_interval is the raw interval; no history registers.

Test Plan:
- Reset/idle: rst high 3 cycles, enable=0, random samples -> all outputs 0, no pulses.
- Clean pulse train: IR square-ish 100/160 with period 50 samples, RED 80/120, HYST=8 -> first peak sets locked, no pulse. Every later peak gives beat_valid, interval 50, ir_ac=60, ir_dc=130, red_ac=40, red_dc=100.
- Refractory: extra spurious peak 10 samples after a valid beat (MIN_INTERVAL=20) -> no beat_valid. Next true peak reports 50, not 40.
- Timeout: flat IR=128 after lock with MAX_INTERVAL=400 -> beat_timeout at sample 400, locked=0, re-ARM, no beat_valid.
- Hysteresis: 4-LSB ripple on a flat 128 baseline -> no state change beyond FALLING, no beats.
- enable drop mid-RISING, then re-enable -> IDLE next cycle, locked=0. Fresh ARM of 16 samples before any detection. With PPG_INTERVAL_AVG_EN: intervals 48, 52, 50, 54 after lock report 48, 49, 49, 51.
